sram_arbiter: RTL and testbench

- Shares one sram-like slave port between two sram-like masters: the instruction port (requester 0) and the data port (requester 1) of the cpu core.
- Sits between the core and the downstream memory bridge.
- Arbitrates address phases and tracks up to OUTSTANDING accepted requests in an in-order ID FIFO.
- Routes each slave data_ok/rdata back to the master that issued the matching request.

---
 rtl/sram_arbiter_pkg.sv | 47 ++++
 rtl/sram_arb_idfifo.sv | 87 ++++++++
 rtl/sram_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
//   Shared definitions for the two-master sram-like arbiter:
//   requester IDs, the sram-like request bundle layout and a packing helper.
package sram_arbiter_pkg;

    // Requester IDs stored in the in-order ID FIFO
    localparam logic REQ_ID_INST = 1'b0;
    localparam logic REQ_ID_DATA = 1'b1;

    // sram-like request bundle: req + wr + size + wstrb + addr + wdata
    localparam int REQ_W      = 72;
    localparam int WDATA_LSB  = 0;
    localparam int ADDR_LSB   = 32;
    localparam int WSTRB_LSB  = 64;
    localparam int SIZE_LSB   = 68;
    localparam int WR_BIT     = 70;
    localparam int REQ_BIT    = 71;

    // Field order matches the offsets above (MSB first)
    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    function automatic sram_req_t pack_req(
        input logic        req,
        input logic        wr,
        input logic [1:0]  size,
        input logic [3:0]  wstrb,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        sram_req_t r;
        r.req   = req;
        r.wr    = wr;
        r.size  = size;
        r.wstrb = wstrb;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/sram_arb_idfifo.sv
// sram_arb_idfifo
//   1-bit wide, DEPTH-deep synchronous FIFO holding the requester ID of every
//   accepted-but-unanswered request, in acceptance order.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears pointers/count)
//   push, push_id   enqueue push_id (ignored when full)
//   pop             dequeue head (ignored when empty)
//   head            ID at the read pointer
//   full, empty     occupancy flags from the registered count
//   count           number of stored IDs (0..DEPTH)
module sram_arb_idfifo
    import sram_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] slot_q, slot_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two pointer ranges would still be safe
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = slot_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = push_id;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot contents are only meaningful below count, so they need no reset
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one sram-like slave port between the instruction master (ID 0) and
//   the data master (ID 1). Data has fixed priority; a granted-but-unaccepted
//   address phase is locked to its owner until accepted or withdrawn. Accepted
//   requests are tracked in an in-order ID FIFO so each slave data_ok/rdata is
//   routed back to the master that issued it.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   inst_* / data_*               sram-like master ports (req, wr, size, wstrb,
//                                 addr, wdata in; addr_ok, data_ok, rdata out)
//   mem_*                         sram-like slave port
//   proto_err                     sticky: slave data_ok seen with no outstanding ID
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int OUT_W       = $clog2(OUTSTANDING) + 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        proto_err
);

    sram_req_t        inst_bus, data_bus, own_bus;
    logic             owner;
    logic             handshake;
    logic             pop_en;
    logic             fifo_head, fifo_full, fifo_empty;
    logic [OUT_W-1:0] fifo_count;

    logic lock_valid_q, lock_valid_d;
    logic lock_owner_q, lock_owner_d;
    logic proto_err_q,  proto_err_d;

    assign inst_bus = pack_req(inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata);
    assign data_bus = pack_req(data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata);

    // Arbitration and address-phase routing; full depends only on registered
    // count, so there is no path from data_ok back into mem_req.
    always_comb begin
        if (lock_valid_q) begin
            owner = lock_owner_q;
        end else if (data_req) begin
            owner = REQ_ID_DATA;
        end else begin
            owner = REQ_ID_INST;
        end
        own_bus   = (owner == REQ_ID_DATA) ? data_bus : inst_bus;

        mem_req   = own_bus.req && !fifo_full;
        mem_wr    = own_bus.wr;
        mem_size  = own_bus.size;
        mem_wstrb = own_bus.wstrb;
        mem_addr  = own_bus.addr;
        mem_wdata = own_bus.wdata;

        handshake    = mem_req && mem_addr_ok;
        inst_addr_ok = handshake && (owner == REQ_ID_INST);
        data_addr_ok = handshake && (owner == REQ_ID_DATA);
    end

    // Lock: hold a presented-but-not-accepted owner. A handshake or the owner
    // dropping req both leave mem_req && !mem_addr_ok false, clearing it.
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        if (!fifo_full) begin
            lock_valid_d = mem_req && !mem_addr_ok;
            if (mem_req && !mem_addr_ok) begin
                lock_owner_d = owner;
            end
        end
    end

    // Response routing by FIFO head
    always_comb begin
        pop_en       = mem_data_ok && (fifo_count != '0);
        inst_data_ok = pop_en && (fifo_head == REQ_ID_INST);
        data_data_ok = pop_en && (fifo_head == REQ_ID_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        proto_err_d  = proto_err_q || (mem_data_ok && fifo_empty);
        proto_err    = proto_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_owner_q <= REQ_ID_INST;
            proto_err_q  <= 1'b0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            proto_err_q  <= proto_err_d;
        end
    end

    sram_arb_idfifo #(
        .DEPTH (OUTSTANDING),
        .CNT_W (OUT_W)
    ) u_idfifo (
        .clk     (clk),
        .reset   (reset),
        .push    (handshake),
        .push_id (owner),
        .pop     (pop_en),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter (OUTSTANDING=2). Inputs change 1 time unit
//   after the rising edge; outputs are checked 1 unit later, mid-cycle.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.OUTSTANDING(2), .OUT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .proto_err    (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'hdeadbeef;
        tick(); tick();
        reset = 1'b0;
        settle();

        // Reset state
        chk("rst_mem_req", mem_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_inst_rdata", inst_rdata, 32'hdeadbeef);
        chk("rst_data_rdata", data_rdata, 32'hdeadbeef);

        // Single inst read: accepted cycle 0, data_ok cycle 2
        tick();
        inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
        settle();
        chk("rd_mem_req", mem_req, 1);
        chk("rd_mem_addr", mem_addr, 32'h1c000000);
        chk("rd_mem_wr", mem_wr, 0);
        chk("rd_inst_addr_ok", inst_addr_ok, 1);
        chk("rd_data_addr_ok", data_addr_ok, 0);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        settle();
        chk("rd_c1_mem_req", mem_req, 0);
        chk("rd_c1_inst_data_ok", inst_data_ok, 0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h02c00000;
        settle();
        chk("rd_inst_data_ok", inst_data_ok, 1);
        chk("rd_data_data_ok", data_data_ok, 0);
        chk("rd_inst_rdata", inst_rdata, 32'h02c00000);
        tick();
        mem_data_ok = 0;

        // Contention: data store wins, inst granted next cycle
        inst_req = 1; inst_addr = 32'h1c000100;
        data_req = 1; data_wr = 1; data_addr = 32'h1c008000;
        data_wstrb = 4'hf; data_wdata = 32'h12345678;
        mem_addr_ok = 1;
        settle();
        chk("ct_mem_wr", mem_wr, 1);
        chk("ct_mem_addr", mem_addr, 32'h1c008000);
        chk("ct_mem_wdata", mem_wdata, 32'h12345678);
        chk("ct_mem_wstrb", mem_wstrb, 4'hf);
        chk("ct_data_addr_ok", data_addr_ok, 1);
        chk("ct_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 0; data_wr = 0;
        settle();
        chk("ct2_mem_addr", mem_addr, 32'h1c000100);
        chk("ct2_mem_wr", mem_wr, 0);
        chk("ct2_inst_addr_ok", inst_addr_ok, 1);
        chk("ct2_data_addr_ok", data_addr_ok, 0);
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11110000;
        settle();
        chk("ct_drain1_data_data_ok", data_data_ok, 1);
        chk("ct_drain1_inst_data_ok", inst_data_ok, 0);
        tick();
        settle();
        chk("ct_drain2_inst_data_ok", inst_data_ok, 1);
        chk("ct_drain2_data_data_ok", data_data_ok, 0);
        tick();
        mem_data_ok = 0;

        // Lock hold: inst presented, addr_ok low 3 cycles, data rises in cycle 1
        inst_req = 1; inst_addr = 32'h1c000200;
        settle();
        chk("lk0_mem_req", mem_req, 1);
        chk("lk0_mem_addr", mem_addr, 32'h1c000200);
        chk("lk0_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 1; data_addr = 32'h1c008004;
        settle();
        chk("lk1_mem_addr", mem_addr, 32'h1c000200);
        chk("lk1_data_addr_ok", data_addr_ok, 0);
        tick();
        settle();
        chk("lk2_mem_addr", mem_addr, 32'h1c000200);
        tick();
        mem_addr_ok = 1;
        settle();
        chk("lk3_mem_addr", mem_addr, 32'h1c000200);
        chk("lk3_inst_addr_ok", inst_addr_ok, 1);
        chk("lk3_data_addr_ok", data_addr_ok, 0);
        tick();
        settle();
        chk("lk4_mem_addr", mem_addr, 32'h1c008004);
        chk("lk4_data_addr_ok", data_addr_ok, 1);
        chk("lk4_inst_addr_ok", inst_addr_ok, 0);
        tick();

        // Full stall: inst, data outstanding; inst still requesting
        data_req = 0;
        settle();
        chk("fs_mem_req", mem_req, 0);
        chk("fs_inst_addr_ok", inst_addr_ok, 0);
        tick();
        mem_data_ok = 1;
        settle();
        chk("fs_pop_inst_data_ok", inst_data_ok, 1);
        chk("fs_pop_data_data_ok", data_data_ok, 0);
        chk("fs_pop_mem_req", mem_req, 0);
        tick();

        // count=1 (head=data): push inst and pop data in the same cycle
        settle();
        chk("pp_mem_req", mem_req, 1);
        chk("pp_inst_addr_ok", inst_addr_ok, 1);
        chk("pp_data_data_ok", data_data_ok, 1);
        chk("pp_inst_data_ok", inst_data_ok, 0);
        tick();
        mem_data_ok = 0;
        settle();
        chk("pp_after_mem_req", mem_req, 1);
        tick();
        settle();
        chk("pp_full_mem_req", mem_req, 0);
        tick();
        inst_req = 0; mem_data_ok = 1;
        settle();
        chk("pp_route1_inst_data_ok", inst_data_ok, 1);
        chk("pp_route1_data_data_ok", data_data_ok, 0);
        tick();
        settle();
        chk("pp_route2_inst_data_ok", inst_data_ok, 1);
        tick();

        // Empty FIFO data_ok: no routing, sticky proto_err
        settle();
        chk("pe_inst_data_ok", inst_data_ok, 0);
        chk("pe_data_data_ok", data_data_ok, 0);
        chk("pe_before", proto_err, 0);
        tick();
        mem_data_ok = 0;
        settle();
        chk("pe_set", proto_err, 1);
        tick();
        settle();
        chk("pe_sticky", proto_err, 1);

        // Reset with two outstanding
        inst_req = 1; inst_addr = 32'h1c000300; mem_addr_ok = 1;
        tick(); tick();
        settle();
        chk("rm_full_mem_req", mem_req, 0);
        reset = 1;
        tick();
        reset = 0;
        settle();
        chk("rm_proto_err", proto_err, 0);
        chk("rm_mem_req", mem_req, 1);
        chk("rm_inst_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        tick();
        mem_data_ok = 1;
        settle();
        chk("rm_pop1_inst_data_ok", inst_data_ok, 1);
        tick();
        settle();
        chk("rm_stale_inst_data_ok", inst_data_ok, 0);
        chk("rm_stale_data_data_ok", data_data_ok, 0);
        tick();
        mem_data_ok = 0;
        settle();
        chk("rm_stale_proto_err", proto_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
